// File: rtl/my_package.sv
// Shared types for the reorder buffer: CDB broadcast, ROB entry, commit kind.
package my_package;

  parameter int ROB_WIDTH = 4;
  parameter int ROB_DEPTH = 2 ** ROB_WIDTH;
  parameter int N_CDB     = 3;

  typedef enum logic [2:0] {
    COMMIT_GPR    = 3'd0,
    COMMIT_FPR    = 3'd1,
    COMMIT_STORE  = 3'd2,
    COMMIT_BRANCH = 3'd3,
    COMMIT_NOP    = 3'd4
  } commit_ring_entry;

  typedef struct packed {
    logic                 valid;
    logic [ROB_WIDTH-1:0] tag;
    logic [31:0]          data;
  } cdb_t;

  typedef struct packed {
    logic        valid;
    logic [31:0] data;
  } rob_entry;

  function automatic logic tag_match(cdb_t c, logic [ROB_WIDTH-1:0] tag);
    return c.valid && (c.tag == tag);
  endfunction

endpackage

// File: rtl/rob_read_port.sv
// Tag-indexed operand lookup into the ROB array for reservation-station fill.
// ROB_CDB_BYPASS_EN: a same-cycle CDB broadcast to the queried tag wins over stored state.
module rob_read_port
  import my_package::*;
#(
  parameter int ROB_WIDTH = my_package::ROB_WIDTH,
  parameter int N_CDB     = my_package::N_CDB,
  localparam int DEPTH    = 1 << ROB_WIDTH
) (
  input  rob_entry [DEPTH-1:0]  ent,
`ifdef ROB_CDB_BYPASS_EN
  input  cdb_t     [N_CDB-1:0]  cdb,
`endif
  input  logic [ROB_WIDTH-1:0]  rd_tag,
  output logic                  rd_valid,
  output logic [31:0]           rd_data
);

  always_comb begin
    rd_valid = ent[rd_tag].valid;
    rd_data  = ent[rd_tag].data;
`ifdef ROB_CDB_BYPASS_EN
    for (int i = 0; i < N_CDB; i++) begin
      if (tag_match(cdb[i], rd_tag)) begin
        rd_valid = 1'b1;
        rd_data  = cdb[i].data;
      end
    end
`endif
  end

endmodule

// File: rtl/reorder_buffer.sv
// Circular reorder buffer: tail allocation, CDB completion by tag, in-order head retire.
// ROB_CDB_BYPASS_EN enables same-cycle CDB forwarding on the operand read ports only.
module reorder_buffer
  import my_package::*;
#(
  parameter int ROB_WIDTH = my_package::ROB_WIDTH,
  parameter int N_CDB     = my_package::N_CDB
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  alloc_req,
  input  commit_ring_entry      alloc_type,
  output logic                  alloc_ok,
  output logic [ROB_WIDTH-1:0]  alloc_tag,
  input  cdb_t [N_CDB-1:0]      cdb,
  input  logic [ROB_WIDTH-1:0]  rd_tag_a,
  input  logic [ROB_WIDTH-1:0]  rd_tag_b,
  output logic                  rd_valid_a,
  output logic                  rd_valid_b,
  output logic [31:0]           rd_data_a,
  output logic [31:0]           rd_data_b,
  output logic                  commit_valid,
  output commit_ring_entry      commit_type,
  output logic [ROB_WIDTH-1:0]  commit_tag,
  output logic [31:0]           commit_data,
  input  logic                  commit_ready,
  input  logic                  flush,
  output logic [ROB_WIDTH:0]    count
);

  localparam int DEPTH = 1 << ROB_WIDTH;
  localparam logic [ROB_WIDTH:0] FULL_CNT = (ROB_WIDTH+1)'(DEPTH);

  logic [ROB_WIDTH-1:0] head_q, head_d, tail_q, tail_d;
  logic [ROB_WIDTH:0]   count_q, count_d;
  rob_entry [DEPTH-1:0] ent_q, ent_d;
  commit_ring_entry     type_q [DEPTH];
  commit_ring_entry     type_d [DEPTH];
  logic                 do_alloc, do_commit;

  assign alloc_ok     = (count_q != FULL_CNT);
  assign alloc_tag    = tail_q;
  assign do_alloc     = alloc_req && alloc_ok;
  assign commit_valid = (count_q != '0) && ent_q[head_q].valid;
  assign do_commit    = commit_valid && commit_ready;
  assign commit_tag   = head_q;
  assign commit_type  = type_q[head_q];
  assign commit_data  = ent_q[head_q].data;
  assign count        = count_q;

  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    ent_d   = ent_q;
    type_d  = type_q;
    if (flush) begin
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
      for (int i = 0; i < DEPTH; i++) ent_d[i].valid = 1'b0;
    end else begin
      for (int i = 0; i < N_CDB; i++) begin
        if (cdb[i].valid) begin
          ent_d[cdb[i].tag].valid = 1'b1;
          ent_d[cdb[i].tag].data  = cdb[i].data;
        end
      end
      // Allocation after CDB writes: a stale broadcast to the tail slot must not mark it done.
      if (do_alloc) begin
        ent_d[tail_q].valid = 1'b0;
        type_d[tail_q]      = alloc_type;
        tail_d              = tail_q + ROB_WIDTH'(1);
      end
      if (do_commit) head_d = head_q + ROB_WIDTH'(1);
      count_d = count_q + (ROB_WIDTH+1)'(do_alloc) - (ROB_WIDTH+1)'(do_commit);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      ent_q   <= '0;
      for (int i = 0; i < DEPTH; i++) type_q[i] <= COMMIT_GPR;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
      ent_q   <= ent_d;
      type_q  <= type_d;
    end
  end

  rob_read_port #(.ROB_WIDTH(ROB_WIDTH), .N_CDB(N_CDB)) u_rd_a (
    .ent      (ent_q),
`ifdef ROB_CDB_BYPASS_EN
    .cdb      (cdb),
`endif
    .rd_tag   (rd_tag_a),
    .rd_valid (rd_valid_a),
    .rd_data  (rd_data_a)
  );

  rob_read_port #(.ROB_WIDTH(ROB_WIDTH), .N_CDB(N_CDB)) u_rd_b (
    .ent      (ent_q),
`ifdef ROB_CDB_BYPASS_EN
    .cdb      (cdb),
`endif
    .rd_tag   (rd_tag_b),
    .rd_valid (rd_valid_b),
    .rd_data  (rd_data_b)
  );

endmodule

// File: doc/reorder_buffer.md
# reorder_buffer

- Circular reorder buffer of 2^ROB_WIDTH entries between dispatch and the commit ring.
- Dispatch allocates a tag at the tail; execution units write results by tag over the CDBs.
- Completed entries retire in program order from the head to the commit stage.
- Provides two tag-indexed operand read ports for reservation-station fill, and empties in one cycle on flush.

## Interface
- ROB_WIDTH, default my_package::ROB_WIDTH (4): log2 of entry count.
- N_CDB, default 3: number of CDB broadcast buses.
- clk  in  1  sole clock; all state on rising edge.
- reset  in  1  asynchronous, active-high.
- alloc_req  in  1  dispatch requests one entry this cycle.
- alloc_type  in  3 (commit_ring_entry)  kind of instruction being allocated.
- alloc_ok  out  1  = !full; allocation happens iff alloc_req && alloc_ok.
- alloc_tag  out  ROB_WIDTH  tag that the allocation receives (= tail pointer).
- cdb  in  cdb_t[N_CDB]  result broadcasts {valid, tag, data}.
- rd_tag_a, rd_tag_b  in  ROB_WIDTH  operand tags queried.
- rd_valid_a, rd_valid_b  out  1  result for the queried tag available.
- rd_data_a, rd_data_b  out  32  result data; don't-care when rd_valid low.
- commit_valid  out  1  head entry allocated and completed.
- commit_type  out  3  commit_ring_entry of head.
- commit_tag  out  ROB_WIDTH  head pointer.
- commit_data  out  32  head result.
- commit_ready  in  1  commit stage accepts head this cycle.
- flush  in  1  discard all entries (mispredict).
- count  out  ROB_WIDTH+1  occupied entries, 0..2^ROB_WIDTH.

## Operation
- State:
  - head and tail, each ROB_WIDTH bits, wrap naturally modulo 2^ROB_WIDTH.
  - count register.
  - Per entry: rob_entry {valid, data} and type.
- full = (count == 2^ROB_WIDTH); empty = (count == 0).
- Allocate:
  - entry[tail].valid <= 0, type <= alloc_type.
  - tail <= tail+1.
- CDB write:
  - For each cdb[i].valid, entry[cdb[i].tag] <= {1, data}.
  - Tags are unique in flight, so at most one bus targets a given entry per cycle.
- Commit:
  - commit_valid = !empty && entry[head].valid.
  - A commit occurs when commit_valid && commit_ready; then head <= head+1.
- count <= count + alloc − commit.
  - Alloc and commit in the same cycle leave count unchanged.
  - Allocation when full is refused even if a commit happens that cycle: no full-bypass.
- Read ports:
  - rd_valid_x = entry[rd_tag_x].valid, rd_data_x = entry[rd_tag_x].data.
  - CDB bypass rules are under Configuration.
- Commit outputs are read from the array only, with no CDB bypass.
- Flush has priority over alloc and CDB writes in the same cycle:
  - head <= 0, tail <= 0, count <= 0, all valid <= 0.
  - A commit handshake in the flush cycle still counts as completed for the consumer.
- A CDB tag naming an unallocated entry is legal and harmless: the entry is overwritten on its next allocation.

## Timing
- Reset values:
  - head = tail = count = 0, all entry valid = 0.
  - alloc_ok = 1, alloc_tag = 0, commit_valid = 0, rd_valid_a/b = 0 (rd_data 0), commit_tag = 0.
- alloc_tag and alloc_ok are combinational from registers and stable throughout the cycle.
- Minimum latency:
  - Allocation in cycle t.
  - CDB result at t+1.
  - commit_valid asserted at t+2.
- commit_* holds stable while commit_valid && !commit_ready.
- Reset mid-operation: asynchronous clear to the values above, no handshake completes.

## Configuration
- ROB_CDB_BYPASS_EN defined:
  - If any cdb[i] tag_match rd_tag_x this cycle, rd_valid_x = 1 and rd_data_x = that cdb data.
  - The CDB has priority over the stored entry.
- Not defined: the read ports see only stored state, so a CDB result is visible one cycle after broadcast.
- Commit path is identical in both builds.

## Structure
- my_package already holds cdb_t, tag_match, rob_entry, commit_ring_entry and ROB_WIDTH.
- Add to my_package: ROB_DEPTH = 2**ROB_WIDTH and parameter N_CDB.
- Sub-module rob_read_port: one instance per read port.
  - Combinational: array lookup plus the optional CDB bypass loop using tag_match.
- reorder_buffer holds all sequential state.

## Test plan
- Reset, then 16 allocs with no CDB:
  - alloc_tag runs 0..15, count = 16, alloc_ok = 0.
  - 17th alloc_req is ignored, tail stays 0.
- Alloc tag 0 (COMMIT_GPR) at t, cdb[0] = {1, 0, 32'hDEADBEEF} at t+1:
  - commit_valid = 1 at t+2 with data DEADBEEF, type COMMIT_GPR.
  - commit_ready = 1 -> count 0.
- Out-of-order completion, tags 0,1,2 allocated, CDB order 2,1,0:
  - No commit_valid until tag 0 completes.
  - Then tags 0,1,2 commit in consecutive cycles.
- Full ROB with head completed, alloc_req && commit_ready in the same cycle:
  - Commit occurs, allocation refused, count = 15.
  - Next cycle alloc_ok = 1 and alloc_tag = old head.
- rd_tag_a = 5 while cdb[2] = {1, 5, 32'h1234}:
  - With ROB_CDB_BYPASS_EN: rd_valid_a = 1, data 1234 the same cycle.
  - Without: 0 that cycle, 1 the next.
- 10 entries in flight, flush with alloc_req high:
  - Next cycle count = 0, alloc_tag = 0, commit_valid = 0.
  - A stale CDB write to tag 3 afterwards is overwritten by re-allocation of tag 3.
